// File: rtl/sub_serial_ctrl.sv
// Bit-serial unsigned subtractor with valid/ready handshakes on both sides.
// One full-subtractor cell per cycle, LSB first; result held until consumed.
module sub_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             x, y, d, bnext, last_bit;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_bit) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode the state only, never the live inputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign x     = a_q[0];
    assign y     = b_q[0];
    assign d     = x ^ y ^ borrow_q;
    assign bnext = (~x & y) | (~(x ^ y) & borrow_q);

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        if (state_q == IDLE && in_valid) begin
            a_d      = a;
            b_d      = b;
            res_d    = '0;
            cnt_d    = '0;
            borrow_d = 1'b0;
            ovf_d    = 1'b0;
            zero_d   = 1'b0;
        end else if (state_q == RUN) begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            res_d    = {d, res_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CW'(1);
            borrow_d = bnext;
            // Overflow is borrow-in vs borrow-out of the sign bit; zero uses the completed word.
            if (last_bit) begin
                ovf_d  = borrow_q ^ bnext;
                zero_d = (res_d == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign diff = res_q;
    assign bout = borrow_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_sub_serial_ctrl.sv
// Randomized self-checking bench for sub_serial_ctrl (WIDTH=8) against an
// arithmetic reference model, plus directed corner and reset cases.
module tb_sub_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout, ovf, zero, busy;

    int checks = 0;
    int errors = 0;

    sub_serial_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void ref_sub(input int av, input int bv,
                                    output int rd, output int rb, output int ro, output int rz);
        int sa, sb, r;
        rd = (av - bv + (1 << W)) % (1 << W);
        rb = (av < bv) ? 1 : 0;
        sa = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
        sb = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
        r  = sa - sb;
        ro = (r < -(1 << (W - 1)) || r > (1 << (W - 1)) - 1) ? 1 : 0;
        rz = (rd == 0) ? 1 : 0;
    endfunction

    task automatic check_result(input int ed, input int eb, input int eo, input int ez);
        check_eq("out_valid", out_valid, 1);
        check_eq("hold_in_ready", in_ready, 0);
        check_eq("diff", diff, ed);
        check_eq("bout", bout, eb);
        check_eq("ovf", ovf, eo);
        check_eq("zero", zero, ez);
    endtask

    task automatic do_op(input int av, input int bv, input int hold_gap, input bit noise);
        int n, ed, eb, eo, ez;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check_eq("idle_in_ready", in_ready, 1);
        ref_sub(av, bv, ed, eb, eo, ez);
        in_valid = 1'b1;
        a = W'(av);
        b = W'(bv);
        step();
        in_valid = 1'b0;
        check_eq("run_busy", busy, 1);
        n = 1;
        while (!out_valid && n < 40) begin
            if (noise) begin
                in_valid  = 1'($urandom);
                a         = W'($urandom);
                b         = W'($urandom);
                out_ready = 1'($urandom);
            end
            step();
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("latency", n, W + 1);
        for (int i = 0; i < hold_gap; i++) begin
            check_result(ed, eb, eo, ez);
            in_valid = noise ? 1'($urandom) : 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            step();
        end
        check_result(ed, eb, eo, ez);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("post_in_ready", in_ready, 1);
        check_eq("post_out_valid", out_valid, 0);
        check_eq("post_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 8'hAA;
        b         = 8'h55;
        step();
        step();
        step();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_diff", diff, 0);
        check_eq("rst_flags", {bout, ovf, zero}, 0);

        do_op(8'h5A, 8'h23, 0, 1'b0);
        check_eq("c1_diff_const", diff, 8'h37);
        do_op(8'h10, 8'h20, 1, 1'b0);
        check_eq("c2_flags_const", {diff, bout, ovf}, {8'hF0, 1'b1, 1'b0});
        do_op(8'h80, 8'h01, 0, 1'b0);
        check_eq("c3_flags_const", {diff, bout, ovf}, {8'h7F, 1'b0, 1'b1});
        do_op(8'h3C, 8'h3C, 0, 1'b0);
        check_eq("c4_flags_const", {diff, bout, ovf, zero}, {8'h00, 1'b0, 1'b0, 1'b1});
        do_op(8'h00, 8'hFF, 0, 1'b0);
        check_eq("c5_flags_const", {diff, bout}, {8'h01, 1'b1});
        do_op(8'hC3, 8'h19, 5, 1'b0);

        // Reset during RUN cycle 4 discards the operation.
        in_valid = 1'b1;
        a = 8'hF0;
        b = 8'h0F;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check_eq("mid_busy", busy, 1);
        rst = 1'b1;
        in_valid = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check_eq("mid_rst_in_ready", in_ready, 1);
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_diff", diff, 0);
        check_eq("mid_rst_flags", {bout, ovf, zero}, 0);
        do_op(8'h01, 8'h01, 0, 1'b0);
        check_eq("after_rst_zero", {diff, zero}, {8'h00, 1'b1});

        for (int k = 0; k < 1000; k++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) step();
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 3)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
